// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu datapath.
// PC select encoding and branch offset width.
package mycpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_JMP  = 2'b11
  } pc_sel_t;

  localparam int BR_OFF_W = 6;

endpackage

// File: rtl/pc_ir.sv
// Program counter and instruction register with a load-valid flag
// and a saturating count of PC updates.
import mycpu_pkg::*;

module pc_ir #(
  parameter logic [15:0] PC_RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ps_in,
  input  logic        il_in,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] a_in,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
  output logic        ir_valid_out,
  output logic [15:0] retired_out
);

  logic [15:0]         pc_q;
  logic [15:0]         pc_nxt;
  logic [15:0]         ir_q;
  logic                valid_q;
  logic [15:0]         ret_q;
  logic [BR_OFF_W-1:0] br_off;
  logic [15:0]         br_ext;
  pc_sel_t             ps;

  assign ps     = pc_sel_t'(ps_in);
  // Offset comes from the instruction currently held, not the fetch bus.
  assign br_off = {ir_q[8:6], ir_q[2:0]};
  assign br_ext = {{(16-BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off};

  always_comb begin
    pc_nxt = pc_q;
    unique case (ps)
      PS_HOLD: pc_nxt = pc_q;
      PS_INC:  pc_nxt = pc_q + 16'd1;
      PS_BR:   pc_nxt = pc_q + br_ext;
      PS_JMP:  pc_nxt = a_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_RST_VAL;
      ir_q    <= 16'h0000;
      valid_q <= 1'b0;
      ret_q   <= 16'h0000;
    end else begin
      pc_q <= pc_nxt;
      if (il_in) begin
        ir_q    <= mem_data_in;
        valid_q <= 1'b1;
      end
      if (ps != PS_HOLD && ret_q != 16'hFFFF)
        ret_q <= ret_q + 16'd1;
    end
  end

  assign pc_out       = pc_q;
  assign ins_out      = ir_q;
  assign ir_valid_out = valid_q;
  assign retired_out  = ret_q;

endmodule

// File: tb/tb_pc_ir.sv
// Directed self-checking bench for pc_ir.
// Expected values are hand-computed per vector.
module tb_pc_ir;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] mem_data_in;
  logic [15:0] a_in;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        ir_valid_out;
  logic [15:0] retired_out;

  int n_chk;
  int n_err;

  pc_ir dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps_in        (ps_in),
    .il_in        (il_in),
    .mem_data_in  (mem_data_in),
    .a_in         (a_in),
    .ins_out      (ins_out),
    .pc_out       (pc_out),
    .ir_valid_out (ir_valid_out),
    .retired_out  (retired_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ps, input logic il,
                       input logic [15:0] mem, input logic [15:0] a);
    ps_in       = ps;
    il_in       = il;
    mem_data_in = mem;
    a_in        = a;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_ir", ins_out, 16'h0000);
    chk("rst_valid", {15'd0, ir_valid_out}, 16'h0000);
    chk("rst_ret", retired_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // fetch then increment
    drive(2'b00, 1'b1, 16'h1234, 16'h0000);
    step();
    chk("fetch_ir", ins_out, 16'h1234);
    chk("fetch_valid", {15'd0, ir_valid_out}, 16'h0001);
    chk("fetch_pc", pc_out, 16'h0000);
    drive(2'b01, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("inc_pc", pc_out, 16'h0001);
    chk("inc_ret", retired_out, 16'h0001);

    // branch -2 from 0x0010
    drive(2'b11, 1'b0, 16'h0000, 16'h0010);
    step();
    chk("jmp10_pc", pc_out, 16'h0010);
    drive(2'b00, 1'b1, 16'h01C6, 16'h0000);
    step();
    drive(2'b10, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("br_neg_pc", pc_out, 16'h000E);
    chk("br_neg_ret", retired_out, 16'h0003);

    // branch +5 from 0x0010
    drive(2'b11, 1'b0, 16'h0000, 16'h0010);
    step();
    drive(2'b00, 1'b1, 16'h0005, 16'h0000);
    step();
    drive(2'b10, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("br_pos_pc", pc_out, 16'h0015);

    // jump and wrap
    drive(2'b11, 1'b0, 16'h0000, 16'hBEEF);
    step();
    chk("jmp_pc", pc_out, 16'hBEEF);
    drive(2'b11, 1'b0, 16'h0000, 16'hFFFF);
    step();
    drive(2'b01, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("wrap_pc", pc_out, 16'h0000);
    chk("wrap_ret", retired_out, 16'h0008);

    // simultaneous load and branch
    drive(2'b11, 1'b0, 16'h0000, 16'h0005);
    step();
    drive(2'b00, 1'b1, 16'h0001, 16'h0000);
    step();
    drive(2'b10, 1'b1, 16'hABCD, 16'h0000);
    step();
    chk("sim_pc", pc_out, 16'h0006);
    chk("sim_ir", ins_out, 16'hABCD);
    chk("sim_ret", retired_out, 16'h000A);

    // asynchronous reset mid-run
    drive(2'b11, 1'b0, 16'h0000, 16'h0042);
    step();
    chk("pre_rst_pc", pc_out, 16'h0042);
    drive(2'b01, 1'b1, 16'h5555, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, 16'h0000);
    chk("arst_ir", ins_out, 16'h0000);
    chk("arst_valid", {15'd0, ir_valid_out}, 16'h0000);
    chk("arst_ret", retired_out, 16'h0000);
    step();
    chk("arst_hold_pc", pc_out, 16'h0000);
    chk("arst_hold_ir", ins_out, 16'h0000);
    rst_n = 1'b1;
    drive(2'b01, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("post_rst_pc", pc_out, 16'h0001);
    chk("post_rst_ret", retired_out, 16'h0001);
    chk("post_rst_valid", {15'd0, ir_valid_out}, 16'h0000);

    // saturation: 65533 more increments reach 0xFFFE
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_pre_ret", retired_out, 16'hFFFE);
    chk("sat_pre_pc", pc_out, 16'hFFFE);
    step();
    chk("sat_full_ret", retired_out, 16'hFFFF);
    step();
    step();
    chk("sat_hold_ret", retired_out, 16'hFFFF);
    chk("sat_pc", pc_out, 16'h0001);
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
    step();
    step();
    chk("idle_ret", retired_out, 16'hFFFF);
    chk("idle_pc", pc_out, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
